// File: rtl/rsa_pkg.sv
// Shared encodings and default widths for the modular-exponentiation datapath.
package rsa_pkg;
  localparam int WIDTH_DEF     = 512;
  localparam int EXP_WIDTH_DEF = 512;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_ISSUE = 4'd1;
  localparam logic [3:0] ST_WAIT  = 4'd2;
  localparam logic [3:0] ST_DONE  = 4'd3;

  typedef logic [1:0] op_t;
  localparam op_t OP_PRE  = 2'd0;
  localparam op_t OP_SQ   = 2'd1;
  localparam op_t OP_MUL  = 2'd2;
  localparam op_t OP_POST = 2'd3;
endpackage

// File: rtl/mont_exp_scheduler_if.sv
// Command-side and core-side bus of the exponentiation scheduler.
interface mont_exp_scheduler_if #(
  parameter int WIDTH     = 512,
  parameter int EXP_WIDTH = 512,
  parameter int LEN_W     = $clog2(EXP_WIDTH) + 1
);
  logic                 start;
  logic [WIDTH-1:0]     x_in, r_in, r2_in, m_in;
  logic [EXP_WIDTH-1:0] e_in;
  logic [LEN_W-1:0]     e_len;
  logic                 busy, done;
  logic [WIDTH-1:0]     result;
  logic                 mult_start;
  logic [WIDTH-1:0]     mult_a, mult_b, mult_m, mult_result;
  logic                 mult_done;
  logic [3:0]           dbg_state;

  modport master (
    output start, x_in, r_in, r2_in, m_in, e_in, e_len, mult_result, mult_done,
    input  busy, done, result, mult_start, mult_a, mult_b, mult_m, dbg_state
  );
  modport slave (
    input  start, x_in, r_in, r2_in, m_in, e_in, e_len, mult_result, mult_done,
    output busy, done, result, mult_start, mult_a, mult_b, mult_m, dbg_state
  );
endinterface

// File: rtl/exp_bit_walker.sv
// Holds the latched exponent and walks its bit index from MSB down to 0.
module exp_bit_walker #(
  parameter int EXP_WIDTH = 512,
  parameter int LEN_W     = $clog2(EXP_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [EXP_WIDTH-1:0] e_in,
  input  logic [LEN_W-1:0]     len,
  input  logic                 step,
  output logic                 cur_bit,
  output logic                 last_bit
);
  localparam int IW = LEN_W - 1;

  logic [EXP_WIDTH-1:0] e_q, e_sh;
  logic [IW-1:0]        idx;
  logic [LEN_W-1:0]     len_m1;

  // len==0 wraps here, but the scheduler never consults the index in that case
  assign len_m1 = len - LEN_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q <= '0;
      idx <= '0;
    end else if (load) begin
      e_q <= e_in;
      idx <= len_m1[IW-1:0];
    end else if (step && idx != '0) begin
      idx <= idx - IW'(1);
    end
  end

  assign e_sh     = e_q >> idx;
  assign cur_bit  = e_sh[0];
  assign last_bit = (idx == '0);
endmodule

// File: rtl/mont_exp_scheduler.sv
// Drives one Montgomery core through pre-conversion, left-to-right square-and-multiply
// and post-conversion to produce X^E mod M.
module mont_exp_scheduler
  import rsa_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int EXP_WIDTH = EXP_WIDTH_DEF,
  parameter int LEN_W     = $clog2(EXP_WIDTH) + 1
) (
  input logic                 clk,
  input logic                 resetn,
  mont_exp_scheduler_if.slave bus
);
  localparam logic [LEN_W-1:0] EMAX = LEN_W'(EXP_WIDTH);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [3:0]       state;
  op_t              op, op_nxt;
  logic [WIDTH-1:0] acc, xt, acc_nxt, xt_nxt, b_nxt;
  logic [WIDTH-1:0] a_q, b_q, m_q, res_q;
  logic             busy_q, done_q, len_zero;
  logic             cur_bit, last_bit, step_req, accept, advance;
  logic [LEN_W-1:0] len_c;

  assign accept  = (state == ST_IDLE) && bus.start;
  assign advance = (state == ST_WAIT) && bus.mult_done;
  assign len_c   = (bus.e_len > EMAX) ? EMAX : bus.e_len;

  exp_bit_walker #(.EXP_WIDTH(EXP_WIDTH), .LEN_W(LEN_W)) u_walk (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .e_in     (bus.e_in),
    .len      (len_c),
    .step     (advance && step_req),
    .cur_bit  (cur_bit),
    .last_bit (last_bit)
  );

  // Next op and its operands, evaluated as if the core result is being accepted now
  always_comb begin
    op_nxt   = op;
    step_req = 1'b0;
    acc_nxt  = acc;
    xt_nxt   = xt;
    case (op)
      OP_PRE: begin
        xt_nxt = bus.mult_result;
        op_nxt = len_zero ? OP_POST : OP_SQ;
      end
      OP_SQ: begin
        acc_nxt = bus.mult_result;
        if (cur_bit)       op_nxt = OP_MUL;
        else if (last_bit) op_nxt = OP_POST;
        else begin
          op_nxt   = OP_SQ;
          step_req = 1'b1;
        end
      end
      OP_MUL: begin
        acc_nxt = bus.mult_result;
        if (last_bit) op_nxt = OP_POST;
        else begin
          op_nxt   = OP_SQ;
          step_req = 1'b1;
        end
      end
      default: op_nxt = OP_POST;
    endcase
    b_nxt = acc_nxt;
    case (op_nxt)
      OP_MUL:  b_nxt = xt_nxt;
      OP_POST: b_nxt = ONE;
      default: b_nxt = acc_nxt;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      op       <= OP_PRE;
      acc      <= '0;
      xt       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      len_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (bus.start) begin
          a_q      <= bus.x_in;
          b_q      <= bus.r2_in;
          m_q      <= bus.m_in;
          acc      <= bus.r_in;
          op       <= OP_PRE;
          len_zero <= (len_c == '0);
          busy_q   <= 1'b1;
          state    <= ST_ISSUE;
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: if (bus.mult_done) begin
          acc <= acc_nxt;
          xt  <= xt_nxt;
          op  <= op_nxt;
          if (op == OP_POST) begin
            res_q  <= bus.mult_result;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            a_q   <= acc_nxt;
            b_q   <= b_nxt;
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = res_q;
  assign bus.mult_start = (state == ST_ISSUE);
  assign bus.mult_a     = a_q;
  assign bus.mult_b     = b_q;
  assign bus.mult_m     = m_q;
  assign bus.dbg_state  = state;
endmodule

// File: tb/tb_mont_exp_scheduler.sv
// Randomized bench: behavioural Montgomery core plus an operand/result scoreboard.
module tb_mont_exp_scheduler;
  localparam int W = 16, EW = 16, LW = 5, LAT = 4;
  localparam longint RMOD = 65536;

  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;

  mont_exp_scheduler_if #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) bus ();
  mont_exp_scheduler #(.WIDTH(W), .EXP_WIDTH(EW), .LEN_W(LW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));

  int n_chk = 0, n_fail = 0;
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // behavioural core: a*b*R^-1 mod M, result LAT cycles after the start is seen
  longint rinv = 1;
  function automatic longint mont(longint a, longint b, longint m);
    return (((a * b) % m) * rinv) % m;
  endfunction

  logic core_busy, core_done, inj_done = 1'b0;
  logic [W-1:0] core_res, ca, cb, cm;
  int core_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      core_busy <= 1'b0; core_done <= 1'b0; core_cnt <= 0;
      core_res <= '0; ca <= '0; cb <= '0; cm <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_busy) begin
        if (core_cnt == 0) begin
          core_done <= 1'b1;
          core_res  <= W'(mont(longint'(ca), longint'(cb), longint'(cm)));
          core_busy <= 1'b0;
        end else core_cnt <= core_cnt - 1;
      end else if (bus.mult_start) begin
        core_busy <= 1'b1; core_cnt <= LAT - 1;
        ca <= bus.mult_a; cb <= bus.mult_b; cm <= bus.mult_m;
      end
    end
  end
  assign bus.mult_done   = core_done | inj_done;
  assign bus.mult_result = core_res;

  // scoreboard
  logic [W-1:0] q_a[$], q_b[$];
  longint exp_m, exp_res;
  int exp_starts, starts_seen, done_cnt = 0;
  bit expecting = 1'b0;

  function automatic longint powmod(longint x, logic [EW-1:0] e, int len, longint m);
    longint r = 1 % m, b = x % m;
    for (int i = 0; i < len; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r;
  endfunction

  task automatic model(input longint x, input logic [EW-1:0] e, input int len_in,
                       input longint m, output longint r, output longint r2);
    int len = (len_in > EW) ? EW : len_in;
    longint acc, xt;
    r = RMOD % m; r2 = (r * r) % m;
    for (longint i = 1; i < m; i++) if ((r * i) % m == 1) rinv = i;
    q_a.delete(); q_b.delete();
    xt = (x * RMOD) % m; acc = r;
    q_a.push_back(W'(x)); q_b.push_back(W'(r2));
    for (int i = len - 1; i >= 0; i--) begin
      q_a.push_back(W'(acc)); q_b.push_back(W'(acc));
      acc = mont(acc, acc, m);
      if (e[i]) begin
        q_a.push_back(W'(acc)); q_b.push_back(W'(xt));
        acc = mont(acc, xt, m);
      end
    end
    q_a.push_back(W'(acc)); q_b.push_back(W'(1));
    exp_res = powmod(x, e, len, m);
    check("model_consistency", mont(acc, 1, m), exp_res);
    exp_starts = q_a.size(); starts_seen = 0; exp_m = m; expecting = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (bus.mult_start) begin
          if (q_a.size() == 0) check("unexpected_start", 1, 0);
          else begin
            check("op_a", bus.mult_a, q_a.pop_front());
            check("op_b", bus.mult_b, q_b.pop_front());
            check("op_m", bus.mult_m, exp_m);
          end
          starts_seen++;
        end else if (core_busy) begin
          check("hold_a", bus.mult_a, ca);
          check("hold_b", bus.mult_b, cb);
          check("hold_m", bus.mult_m, cm);
        end
        if (bus.done) begin
          check("done_expected", expecting, 1);
          check("result", bus.result, exp_res);
          check("start_count", starts_seen, exp_starts);
          check("busy_at_done", bus.busy, 1);
          expecting = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  task automatic launch(input longint x, input logic [EW-1:0] e, input int len, input longint m);
    longint r, r2;
    model(x, e, len, m, r, r2);
    @(negedge clk);
    bus.x_in = W'(x); bus.r_in = W'(r); bus.r2_in = W'(r2); bus.m_in = W'(m);
    bus.e_in = e; bus.e_len = LW'(len); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // mode 1: re-pulse start mid-run; mode 2: spurious mult_done during first ISSUE
  task automatic run(input longint x, input logic [EW-1:0] e, input int len,
                     input longint m, input int mode);
    int target = done_cnt + 1;
    launch(x, e, len, m);
    if (mode == 2) begin
      inj_done = 1'b1; @(negedge clk); inj_done = 1'b0;
    end
    if (mode == 1) begin
      repeat (12) @(negedge clk);
      check("busy_mid", bus.busy, 1);
      bus.x_in = W'((x + 1) % m); bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_restart", bus.busy, 1);
    end
    for (int c = 0; c < 3000 && done_cnt < target; c++) @(negedge clk);
    if (done_cnt < target) check("done_timeout", 0, 1);
    @(negedge clk);
    check("busy_after_done", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
    check("idle_state", bus.dbg_state, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.x_in = '0; bus.r_in = '0; bus.r2_in = '0; bus.m_in = '0;
    bus.e_in = '0; bus.e_len = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_mult_start", bus.mult_start, 0);
    check("rst_mult_a", bus.mult_a, 0);
    check("rst_state", bus.dbg_state, 0);
    resetn = 1'b1;

    run(2, 16'd5, 3, 13, 0);
    check("lit_res_e5", bus.result, 6);
    check("lit_starts_e5", starts_seen, 7);

    run(2, 16'd5, 0, 13, 2);
    check("lit_res_len0", bus.result, 1);
    check("lit_starts_len0", starts_seen, 2);

    run(2, 16'hFFFF, 16, 13, 1);
    check("lit_res_ffff", bus.result, 8);
    check("lit_starts_ffff", starts_seen, 34);

    // spurious core completion while idle
    @(negedge clk); inj_done = 1'b1; @(negedge clk); inj_done = 1'b0;
    check("idle_inj_state", bus.dbg_state, 0);
    check("idle_inj_busy", bus.busy, 0);
    check("idle_inj_start", bus.mult_start, 0);
    check("idle_inj_result", bus.result, 8);

    // reset while waiting on the core
    launch(3, 16'h1234, 16, 13);
    for (int c = 0; c < 200 && starts_seen < 3; c++) @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_mult_start", bus.mult_start, 0);
    check("midrst_mult_a", bus.mult_a, 0);
    check("midrst_result", bus.result, 0);
    check("midrst_state", bus.dbg_state, 0);
    q_a.delete(); q_b.delete(); expecting = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", bus.done, 0);
    run(3, 16'h1234, 16, 13, 0);

    for (int k = 0; k < 12; k++) begin
      longint m = longint'($urandom_range(1, 127)) * 2 + 1;
      longint x = longint'($urandom_range(0, 32'(m - 1)));
      logic [EW-1:0] e = EW'($urandom);
      int len = int'($urandom_range(0, 20));
      run(x, e, len, m, (k % 3 == 1) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
